clock_div_prog: RTL
===================

# clock_div_prog

Programmable multi-channel clock divider built from a single fully synchronous counter per channel, replacing ripple-flip-flop chains. Each channel produces a near-50%-duty divided clock and a one-cycle tick strobe from the system clock, with a runtime divisor that is updated without glitches at period boundaries. It sits between the board clock and slow consumers such as display scan, debouncers and the game timer. All outputs are registered and are intended for use as clock enables.

## Interface
- `CHANNELS`, default 2: number of independent divider channels.
- `WIDTH`, default 17: counter and divisor width in bits.
- `DEFAULT_DIV`, default 17'd100000: active divisor per channel after reset. Must be ≥ 2 and < 2^WIDTH.

Ports:
- `clock` input, 1 bit: system clock. All logic is on the rising edge.
- `reset` input, 1 bit: synchronous, active-low reset.
- `enable` input, CHANNELS bits: per-channel run enable.
- `divisor` input, CHANNELS*WIDTH bits: channel c occupies bits [c*WIDTH +: WIDTH].
- `load` input, CHANNELS bits: one-cycle request to capture the channel's `divisor` slice.
- `div_clock` output, CHANNELS bits: divided clock per channel.
- `tick` output, CHANNELS bits: one-cycle strobe in the last cycle of each period.
- `pending` output, CHANNELS bits: a loaded divisor is waiting for the next period boundary.

## Operation
Per-channel state:
- `count` (WIDTH bits)
- `active` divisor
- `next_div` shadow register
- `pending` flag

Effective divisor rule:
- N = max(active, 2). A value of 0 or 1 behaves as 2.
- H = N − (N>>1) = ceil(N/2).
- Width rule: N−1 and H fit in WIDTH bits. No wider arithmetic is needed.

Disabled state (`enable[c]`=0):
- `count`←0, `div_clock`←0, `tick`←0.
- `load` writes `active` directly at that edge. `pending` stays 0.

Running state (`enable[c]`=1):
- The edge that first samples `enable`=1 sets `count`←0, `div_clock`←1, `tick`←(N==1 impossible, so 0).
- On each later edge, `count`←(count==N−1) ? 0 : count+1.
- Outputs are registered from the new count: `div_clock`←(new count < H), `tick`←(new count == N−1).
- Waveform: high for H cycles, low for N−H cycles, period N. Duty is exactly 50% for even N; odd N has the extra cycle high.

Divisor update while running:
- `load` sets `next_div`←slice and `pending`←1. A second load before the boundary overwrites `next_div`.
- At the wrap edge (count==N−1): `active`←`next_div`, `pending`←0. The period starting at count 0 uses the new N.
- A `load` on the wrap edge itself captures the new slice and applies it at that same boundary; `pending` remains 0.
- Periods already in progress are never truncated or stretched, so there are no runt pulses.

Channels are fully independent, with no shared state.

## Timing
- Reset (`reset`=0 at an edge) has top priority and holds every channel in the following state:
  - `count`=0, `active`=DEFAULT_DIV, `next_div`=DEFAULT_DIV
  - `pending`=0, `div_clock`=0, `tick`=0
- Reset mid-period discards the partial period and any pending divisor.
- Enable latency: `div_clock` rises in the cycle after the first edge that samples `enable`=1.
- Disable latency: the cycle after the first edge that samples `enable`=0, `div_clock` and `tick` are 0. The partial period is dropped and `pending` is cleared; `active` keeps its value.
- `tick` is high for exactly one cycle per period, coinciding with the last low cycle of `div_clock`.
- `load` and `enable` falling on the same edge: the load writes `active` directly, as in the disabled state.

## Test plan
- **Reset values:** `reset`=0 for 3 cycles, then release with `enable`=0 → all outputs 0, `pending`=0. Then `enable[0]`=1 → `div_clock[0]` has period 100000 (default).
- **Even and odd divisors:** load 4 on ch0 and 5 on ch1 while disabled, then enable both → ch0 produces 1100 repeating and ch1 produces 11100 repeating. `tick` is high on the count-3 and count-4 cycles respectively.
- **Degenerate divisors:** load 0, then 1, then 2 → each case toggles every cycle (period 2), with `tick` high every second cycle.
- **Glitch-free update:** N=6 running; `load`=10 at count 2 → `pending`=1 until the wrap. The current period completes with 6 cycles, the next period is 10 cycles (5 high, 5 low), and `pending` drops at the wrap edge.
- **Load on wrap edge and double load:** load 8 at count N−1 → the next period is 8 cycles and `pending` never rises. Load 12 then 3 before the boundary → the next period is 3 cycles.
- **Mid-operation events:** N=7, deassert `enable` at count 4 → outputs are 0 the next cycle. Re-enable → a full 4-high/3-low period starts. Assert `reset` mid-period → the reset state holds, and after release the channel runs with DEFAULT_DIV.

Source files
------------

// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock divider: one synchronous counter per channel
// producing a registered divided clock, a last-cycle tick and boundary-synchronised divisor updates.
module clock_div_prog #(
  parameter int                CHANNELS    = 2,
  parameter int                WIDTH       = 17,
  parameter logic [WIDTH-1:0]  DEFAULT_DIV = 17'd100000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         enable,
  input  logic [CHANNELS*WIDTH-1:0]   divisor,
  input  logic [CHANNELS-1:0]         load,
  output logic [CHANNELS-1:0]         div_clock,
  output logic [CHANNELS-1:0]         tick,
  output logic [CHANNELS-1:0]         pending
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] next_q, next_d;
    logic             pend_q, pend_d;
    logic             run_q, run_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] n_eff, half, slice;
    logic             wrap;

    assign slice = divisor[c*WIDTH +: WIDTH];

    always_comb begin
      n_eff    = (active_q < WIDTH'(2)) ? WIDTH'(2) : active_q;
      half     = n_eff - (n_eff >> 1);
      wrap     = run_q && (count_q == n_eff - WIDTH'(1));
      count_d  = count_q;
      active_d = active_q;
      next_d   = next_q;
      pend_d   = pend_q;
      run_d    = run_q;
      clk_d    = 1'b0;
      tick_d   = 1'b0;
      if (!enable[c]) begin
        count_d = '0;
        run_d   = 1'b0;
        pend_d  = 1'b0;
        if (load[c]) active_d = slice;
      end else if (!run_q) begin
        run_d   = 1'b1;
        count_d = '0;
        clk_d   = 1'b1;
        if (load[c]) begin
          next_d = slice;
          pend_d = 1'b1;
        end
      end else if (wrap) begin
        // New period starts at count 0; a load on this edge takes effect immediately.
        count_d = '0;
        clk_d   = 1'b1;
        pend_d  = 1'b0;
        if (load[c])     active_d = slice;
        else if (pend_q) active_d = next_q;
      end else begin
        count_d = count_q + WIDTH'(1);
        clk_d   = (count_d < half);
        tick_d  = (count_d == n_eff - WIDTH'(1));
        if (load[c]) begin
          next_d = slice;
          pend_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        count_q  <= '0;
        active_q <= DEFAULT_DIV;
        next_q   <= DEFAULT_DIV;
        pend_q   <= 1'b0;
        run_q    <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        count_q  <= count_d;
        active_q <= active_d;
        next_q   <= next_d;
        pend_q   <= pend_d;
        run_q    <= run_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
      end
    end

    assign div_clock[c] = clk_q;
    assign tick[c]      = tick_q;
    assign pending[c]   = pend_q;
  end

endmodule
